// File: rtl/voice_scheduler.sv
// Time-multiplexed 32-voice sine synthesis controller.
// Sweeps one voice per clock over a shared sine ROM and increment table.
module voice_scheduler #(
  parameter int NUM_VOICES  = 32,
  parameter int ROM_LATENCY = 1,
  parameter int SCALE       = 4000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_req,
  input  logic [NUM_VOICES-1:0]         key_pressed,
  output logic [$clog2(NUM_VOICES)-1:0] inc_index,
  input  logic [16:0]                   increment,
  output logic [7:0]                    rom_address,
  input  logic [11:0]                   rom_q,
  output logic [31:0]                   sound,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int VW = $clog2(NUM_VOICES);
  localparam int DW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [VW-1:0] LP_LAST = VW'(NUM_VOICES - 1);
  localparam logic signed [31:0] LP_SCALE = 32'(SCALE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_phase [NUM_VOICES];
  logic [NUM_VOICES-1:0]  r_keys;
  logic [ROM_LATENCY-1:0] r_kpipe;
  logic signed [17:0]     r_acc;
  logic [DW-1:0]          r_drain;

  logic                   w_run;
  logic                   w_start;
  logic                   w_key_now;
  logic [VW-1:0]          w_vnext;
  logic signed [17:0]     w_sample;
  logic signed [31:0]     w_acc_ext;
  logic signed [31:0]     w_scaled;

  assign w_run     = (r_state == S_RUN);
  assign w_start   = sample_req &&
                     (r_state == S_IDLE || r_state == S_DONE);
  assign w_vnext   = inc_index + VW'(1);
  assign w_key_now = w_run && r_keys[inc_index];
  assign w_sample  = r_kpipe[ROM_LATENCY-1] ?
                     {{6{rom_q[11]}}, rom_q} : '0;
  assign w_acc_ext = {{14{r_acc[17]}}, r_acc};
  assign w_scaled  = w_acc_ext * LP_SCALE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_phase[i] <= '0;
      end
    end else if (w_run) begin
      r_phase[inc_index] <= r_phase[inc_index] +
                            {15'd0, increment};
    end
  end

  // key bit travels with its ROM address; idle slots carry 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kpipe <= '0;
    end else begin
      r_kpipe[0] <= w_key_now;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_kpipe[i] <= r_kpipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_keys       <= '0;
      r_acc        <= '0;
      r_drain      <= '0;
      inc_index    <= '0;
      rom_address  <= '0;
      sound        <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      r_acc        <= r_acc + w_sample;
      unique case (r_state)
        S_IDLE: begin
        end
        S_RUN: begin
          overrun <= sample_req;
          if (inc_index == LP_LAST) begin
            r_state <= S_DRAIN;
            r_drain <= DW'(ROM_LATENCY - 1);
          end else begin
            inc_index   <= w_vnext;
            rom_address <= r_phase[w_vnext][31:24];
          end
        end
        S_DRAIN: begin
          overrun <= sample_req;
          if (r_drain == '0) begin
            r_state <= S_DONE;
          end else begin
            r_drain <= r_drain - DW'(1);
          end
        end
        S_DONE: begin
          sound        <= w_scaled;
          sample_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // a request in DONE chains straight into the next frame
      if (w_start) begin
        r_state     <= S_RUN;
        r_keys      <= key_pressed;
        r_acc       <= '0;
        inc_index   <= '0;
        rom_address <= r_phase[0][31:24];
      end
      busy <= w_start || w_run || (r_state == S_DRAIN);
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: frame-level reference model plus
// directed scenarios with literal expectations.
module tb_voice_scheduler;

  localparam int SCALE = 4000;
  localparam int FRAME = 34;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_req = 1'b0;
  logic [31:0] key_pressed = '0;
  logic [4:0]  inc_index;
  logic [16:0] increment;
  logic [7:0]  rom_address;
  logic [11:0] rom_q = '0;
  logic [31:0] sound;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  int rom_mode = 0;
  int inc_mode = 0;
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  voice_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .sample_req   (sample_req),
    .key_pressed  (key_pressed),
    .inc_index    (inc_index),
    .increment    (increment),
    .rom_address  (rom_address),
    .rom_q        (rom_q),
    .sound        (sound),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  function automatic logic [11:0] rom_fn(input int mode,
                                         input logic [7:0] a);
    case (mode)
      0:       return 12'd100;
      1:       return 12'h800;
      default: return {{4{a[7]}}, a};
    endcase
  endfunction

  function automatic logic [16:0] inc_fn(input int mode,
                                         input logic [4:0] idx);
    if (mode == 0) return 17'h10000;
    return 17'({12'd0, idx} * 17'd4099 + 17'd7);
  endfunction

  assign increment = inc_fn(inc_mode, inc_index);

  always @(posedge clk) rom_q <= rom_fn(rom_mode, rom_address);

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // reference model: whole frame evaluated when it is accepted
  int          m_left = 0;
  logic [31:0] m_phase [32];
  logic [7:0]  m_addr [32];
  logic [31:0] m_pend = '0;
  logic [31:0] exp_sound = '0;
  logic        exp_valid = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_over = 1'b0;

  always @(posedge clk) begin : model
    int old;
    int sum;
    if (reset) begin
      m_left = 0;
      m_pend = '0;
      exp_sound = '0;
      exp_valid = 1'b0;
      exp_busy = 1'b0;
      exp_over = 1'b0;
      for (int i = 0; i < 32; i++) begin
        m_phase[i] = '0;
        m_addr[i] = '0;
      end
    end else begin
      old = m_left;
      exp_valid = (old == 1);
      exp_over = sample_req && (old > 1);
      if (old == 1) exp_sound = m_pend;
      if (sample_req && old <= 1) begin
        sum = 0;
        for (int v = 0; v < 32; v++) begin
          m_addr[v] = m_phase[v][31:24];
          if (key_pressed[v])
            sum += int'($signed(rom_fn(rom_mode, m_addr[v])));
          m_phase[v] = m_phase[v] + 32'(inc_fn(inc_mode, 5'(v)));
        end
        m_pend = 32'(sum * SCALE);
        m_left = FRAME;
      end else if (old > 0) begin
        m_left = old - 1;
      end
      exp_busy = (m_left > 0);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("sample_valid", 32'(sample_valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(exp_busy));
      check("overrun", 32'(overrun), 32'(exp_over));
      check("sound", sound, exp_sound);
      if (m_left >= 3 && m_left <= FRAME) begin
        check("inc_index", 32'(inc_index), 32'(FRAME - m_left));
        check("rom_address", 32'(rom_address),
              32'(m_addr[FRAME - m_left]));
      end
    end
  end

  task automatic pulse_req();
    @(negedge clk) sample_req = 1'b1;
    @(negedge clk) sample_req = 1'b0;
  endtask

  task automatic wait_frame(output int lat, output int bcnt);
    lat = 0;
    bcnt = busy ? 1 : 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end while (!sample_valid && lat < 60);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    int bcnt;
    int vcnt;
    int ocnt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    repeat (10) @(negedge clk);
    check("idle_sound", sound, 32'd0);
    check("idle_valid", 32'(sample_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_overrun", 32'(overrun), 32'd0);
    check("idle_rom_address", 32'(rom_address), 32'd0);

    rom_mode = 0;
    inc_mode = 1;
    key_pressed = 32'h1;
    pulse_req();
    wait_frame(lat, bcnt);
    check("single_latency", 32'(lat), 32'd34);
    check("single_busy_cycles", 32'(bcnt), 32'd34);
    check("single_sound", sound, 32'd400000);

    rom_mode = 1;
    key_pressed = 32'hFFFF_FFFF;
    pulse_req();
    repeat (10) @(negedge clk);
    key_pressed = 32'h0;
    wait_frame(lat, bcnt);
    check("allneg_sound", sound, 32'(-262144000));

    do_reset();
    rom_mode = 2;
    inc_mode = 0;
    key_pressed = 32'h1;
    for (int n = 1; n <= 512; n++) begin
      pulse_req();
      if (n == 1 || n == 256 || n == 257 || n == 512)
        check("sweep_addr0", 32'(rom_address),
              32'(((n - 1) * 65536) >>> 24));
      wait_frame(lat, bcnt);
      check("sweep_latency", 32'(lat), 32'd34);
    end
    check("sweep_sound", sound, 32'd4000);

    key_pressed = 32'hFFFF_FFFF;
    pulse_req();
    repeat (11) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (sample_valid) vcnt++;
    end
    check("abort_valid_count", 32'(vcnt), 32'd0);
    check("abort_sound", sound, 32'd0);
    pulse_req();
    check("restart_addr0", 32'(rom_address), 32'd0);
    wait_frame(lat, bcnt);
    check("restart_latency", 32'(lat), 32'd34);

    rom_mode = 0;
    key_pressed = 32'h3;
    pulse_req();
    repeat (4) @(negedge clk);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    ocnt = overrun ? 1 : 0;
    vcnt = sample_valid ? 1 : 0;
    repeat (40) begin
      @(negedge clk);
      if (overrun) ocnt++;
      if (sample_valid) vcnt++;
    end
    check("overrun_count", 32'(ocnt), 32'd1);
    check("overrun_valid_count", 32'(vcnt), 32'd1);
    check("overrun_sound", sound, 32'd800000);

    pulse_req();
    repeat (33) @(negedge clk);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    check("chain_valid", 32'(sample_valid), 32'd1);
    check("chain_busy", 32'(busy), 32'd1);
    wait_frame(lat, bcnt);
    check("chain_spacing", 32'(lat), 32'd34);
    check("chain_sound", sound, 32'd800000);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
